freq_meter: RTL and testbench

Gated frequency and period meter for a slow square-wave signal, such as the output of a clock divider stage, sampled in the system clock domain. Each gate window of GATE_CYCLES clkin cycles, the block counts the rising edges of the asynchronous input and reports the count with a one-cycle valid strobe. In parallel it measures the clkin-cycle distance between consecutive rising edges. Results feed the display and reporting logic downstream.

---
 rtl/freq_meter.sv | 85 ++++++++
 tb/tb_freq_meter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: gated rising-edge counter and edge-to-edge period meter for a slow asynchronous input.
module freq_meter #(
    parameter int GATE_CYCLES = 1_000_000,
    parameter int CNT_W = 32
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_cnt,
    output logic             freq_valid,
    output logic [CNT_W-1:0] period_cyc,
    output logic             per_valid,
    output logic             ovf,
    output logic             busy
);
    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] GATE = 1'b1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0] state;
    logic s1, s2, s3, rise, armed, win_end;
    logic [GW-1:0] gate_cnt;
    logic [CNT_W-1:0] edge_cnt, per_cnt;

    assign rise = s2 & ~s3;
    assign win_end = gate_cnt == GATE_LAST;
    assign busy = state == GATE;

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            per_cnt <= '0;
            armed <= 1'b0;
            freq_cnt <= '0;
            period_cyc <= '0;
            ovf <= 1'b0;
            freq_valid <= 1'b0;
            per_valid <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            per_valid <= 1'b0;
            // entering a window and aborting one both start from cleared counters
            if (state == IDLE || !en) begin
                state <= en ? GATE : IDLE;
                gate_cnt <= '0;
                edge_cnt <= '0;
                per_cnt <= '0;
                armed <= 1'b0;
            end else begin
                gate_cnt <= win_end ? '0 : gate_cnt + GW'(1);
                edge_cnt <= win_end ? '0 : edge_cnt + CNT_W'(rise);
                if (win_end) begin
                    freq_cnt <= edge_cnt + CNT_W'(rise);
                    freq_valid <= 1'b1;
                end
                per_cnt <= rise ? CNT_W'(1) : (per_cnt == CNT_MAX ? per_cnt : per_cnt + CNT_W'(1));
                if (rise) begin
                    armed <= 1'b1;
                    if (armed) begin
                        period_cyc <= per_cnt;
                        ovf <= per_cnt == CNT_MAX;
                        per_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: two freq_meter instances (long gate / narrow counters) checked every cycle against an edge-timeline model.
module tb_freq_meter;
    localparam int GA = 160, WA = 8, GB = 8, WB = 4, MAXC = 16384;

    logic clkin = 1'b0;
    logic rst_n, en_a, sig_a, en_b, sig_b;
    logic [WA-1:0] fc_a, per_a;
    logic [WB-1:0] fc_b, per_b;
    logic fv_a, pv_a, ovf_a, busy_a, fv_b, pv_b, ovf_b, busy_b;

    int errors = 0, checks = 0, cyc = 0;
    int last_fv = -1, nfv = 0, ph = 0, rate_a = 1, rate_b = 1;
    bit sq_a = 0, steady = 0;

    // model: rise timeline per instance, window/period results derived from edge indices
    bit ra [2][MAXC];
    bit h0 [2], h1 [2], h2 [2], in_g [2], e_fv [2], e_pv [2], e_ovf [2];
    int start [2], last [2], e_freq [2], e_per [2];

    freq_meter #(.GATE_CYCLES(GA), .CNT_W(WA)) u_a (
        .clkin(clkin), .rst_n(rst_n), .en(en_a), .sig_in(sig_a),
        .freq_cnt(fc_a), .freq_valid(fv_a), .period_cyc(per_a),
        .per_valid(pv_a), .ovf(ovf_a), .busy(busy_a)
    );

    freq_meter #(.GATE_CYCLES(GB), .CNT_W(WB)) u_b (
        .clkin(clkin), .rst_n(rst_n), .en(en_b), .sig_in(sig_b),
        .freq_cnt(fc_b), .freq_valid(fv_b), .period_cyc(per_b),
        .per_valid(pv_b), .ovf(ovf_b), .busy(busy_b)
    );

    always #5 clkin = ~clkin;

    task automatic model_edge(input int i, input bit en, input bit sig, input int g, input int w);
        bit r;
        int pmax, d, n;
        pmax = (1 << w) - 1;
        r = h1[i] & ~h2[i];
        h2[i] = h1[i];
        h1[i] = h0[i];
        h0[i] = sig;
        e_fv[i] = 0;
        e_pv[i] = 0;
        if (!rst_n) begin
            h0[i] = 0; h1[i] = 0; h2[i] = 0;
            in_g[i] = 0;
            e_freq[i] = 0; e_per[i] = 0; e_ovf[i] = 0;
        end else if (!in_g[i]) begin
            if (en) begin
                in_g[i] = 1;
                start[i] = cyc + 1;
                last[i] = -1;
            end
        end else if (!en) begin
            in_g[i] = 0;
        end else begin
            if (cyc < MAXC) ra[i][cyc] = r;
            if ((cyc - start[i]) % g == g - 1) begin
                n = 0;
                for (int k = cyc - g + 1; k <= cyc; k++) n += int'(ra[i][k]);
                e_freq[i] = n;
                e_fv[i] = 1;
            end
            if (r) begin
                if (last[i] >= 0) begin
                    d = cyc - last[i];
                    e_per[i] = d > pmax ? pmax : d;
                    e_ovf[i] = d >= pmax;
                    e_pv[i] = 1;
                end
                last[i] = cyc;
            end
        end
    endtask

    always @(posedge clkin) begin
        model_edge(0, en_a, sig_a, GA, WA);
        model_edge(1, en_b, sig_b, GB, WB);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("a.freq_cnt", 32'(fc_a), e_freq[0]);
        chk("a.freq_valid", 32'(fv_a), 32'(e_fv[0]));
        chk("a.period_cyc", 32'(per_a), e_per[0]);
        chk("a.per_valid", 32'(pv_a), 32'(e_pv[0]));
        chk("a.ovf", 32'(ovf_a), 32'(e_ovf[0]));
        chk("a.busy", 32'(busy_a), 32'(in_g[0]));
        chk("b.freq_cnt", 32'(fc_b), e_freq[1]);
        chk("b.freq_valid", 32'(fv_b), 32'(e_fv[1]));
        chk("b.period_cyc", 32'(per_b), e_per[1]);
        chk("b.per_valid", 32'(pv_b), 32'(e_pv[1]));
        chk("b.ovf", 32'(ovf_b), 32'(e_ovf[1]));
        chk("b.busy", 32'(busy_b), 32'(in_g[1]));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clkin);
            @(negedge clkin);
            check_all();
            if (steady) begin
                if (fv_a) begin
                    nfv++;
                    chk("a.steady_freq", 32'(fc_a), 10);
                    if (last_fv >= 0) chk("a.strobe_gap", cyc - last_fv, GA);
                    last_fv = cyc;
                end
                if (pv_a) begin
                    chk("a.steady_period", 32'(per_a), 16);
                    chk("a.steady_ovf", 32'(ovf_a), 0);
                end
            end
            if (sq_a) sig_a = ((cyc + ph) % 16) < 8;
        end
    endtask

    task automatic wait_pv_b(input int budget);
        for (int k = 0; k < budget && !pv_b; k++) tick(1);
        chk("b.per_valid_seen", 32'(pv_b), 1);
    endtask

    initial begin
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; sig_a = 1'b1; sig_b = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(12);
        chk("a.init_freq", 32'(fc_a), 0);
        chk("a.init_busy", 32'(busy_a), 0);
        chk("b.init_period", 32'(per_b), 0);
        sig_b = 1'b0;

        // steady square wave, period 16, into 160-cycle windows
        ph = int'($urandom_range(0, 15));
        sq_a = 1;
        tick(40);
        steady = 1;
        last_fv = -1;
        en_a = 1'b1;
        tick(5 * GA + 4);
        chk("a.steady_strobes", nfv, 5);

        // abort at gate_cnt=50, then a full window
        en_a = 1'b0;
        tick(3);
        last_fv = -1;
        en_a = 1'b1;
        tick(51);
        en_a = 1'b0;
        tick(1);
        chk("a.abort_busy", 32'(busy_a), 0);
        chk("a.abort_hold", 32'(fc_a), 10);
        tick(5);
        last_fv = -1;
        en_a = 1'b1;
        tick(2 * GA + 5);
        steady = 0;

        // reset pulse mid-window
        rst_n = 1'b0;
        tick(1);
        chk("a.rst_freq", 32'(fc_a), 0);
        chk("a.rst_period", 32'(per_a), 0);
        chk("a.rst_busy", 32'(busy_a), 0);
        chk("a.rst_fv", 32'(fv_a), 0);
        rst_n = 1'b1;
        tick(20);

        // rise landing in the final gate cycle
        en_b = 1'b1;
        tick(6);
        sig_b = 1'b1;
        tick(3);
        chk("b.edge_last_valid", 32'(fv_b), 1);
        chk("b.edge_last_cnt", 32'(fc_b), 1);
        tick(8);
        chk("b.next_valid", 32'(fv_b), 1);
        chk("b.next_cnt", 32'(fc_b), 0);

        // period saturation with 4-bit counters
        en_b = 1'b0;
        sig_b = 1'b0;
        tick(3);
        en_b = 1'b1;
        tick(3);
        sig_b = 1'b1;
        tick(4);
        sig_b = 1'b0;
        tick(16);
        sig_b = 1'b1;
        wait_pv_b(10);
        chk("b.sat_period", 32'(per_b), 15);
        chk("b.sat_ovf", 32'(ovf_b), 1);
        sig_b = 1'b0;
        tick(2);
        sig_b = 1'b1;
        wait_pv_b(10);
        chk("b.short_period", 32'(per_b), 5);
        chk("b.short_ovf", 32'(ovf_b), 0);

        // randomized traffic, enables and occasional resets
        sq_a = 0;
        en_a = 1'b1;
        en_b = 1'b1;
        for (int c = 0; c < 1600; c++) begin
            if (c % 200 == 0) begin
                rate_a = int'($urandom_range(1, 60));
                rate_b = int'($urandom_range(1, 12));
            end
            if ($urandom_range(1, rate_a) == 1) sig_a = ~sig_a;
            if ($urandom_range(1, rate_b) == 1) sig_b = ~sig_b;
            if ($urandom_range(0, 249) == 0) en_a = ~en_a;
            if ($urandom_range(0, 99) == 0) en_b = ~en_b;
            rst_n = ($urandom_range(0, 999) != 0);
            tick(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
